datapath_executor: RTL and testbench
====================================

Name: datapath_executor

Overview:
- Sequential datapath that consumes the control word produced by the task controller: operand muxes, a barrel-equivalent shifter, ALU and result register.
- Each control word is accepted through a valid/ready handshake.
- The shifter is iterative, one bit per cycle, so latency depends on shamt.
- Result, register contents and NZCV flags are exposed for the next stage and for the bench.

Parameters:
W, 8, datapath width in bits (W >= 2)

Ports:
clk  input  1  clock, rising edge
reset_synchronous  input  1  synchronous active-high reset
cmd_valid  input  1  control word present
cmd_ready  output  1  executor can accept a control word
MUX0_SELECT  input  1  operand A: 1 = MUX0_INP1, 0 = register R
MUX0_INP1  input  W  immediate for operand A
MUX1_SELECT  input  1  operand B source: 1 = MUX1_INP1, 0 = register R
MUX1_INP1  input  W  immediate for operand B
shamt  input  5  shift amount applied to operand B
combinational_shifter_control  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
op2_mux2_select  input  1  1 = shifted B, 0 = comp2_mux2_inp_1
comp2_mux2_inp_1  input  W  alternate operand B (constant)
ALU_OPERATION_SELECT  input  4  ALU opcode
write_enable  input  1  1 = write ALU result into R
busy  output  1  command in flight
done  output  1  one-cycle pulse: result and flags updated
result  output  W  last ALU result
reg_out  output  W  register R
flags  output  4  {N,Z,C,V}

Behaviour:
- Reset (reset_synchronous=1 at an edge) overrides everything:
  - State goes to IDLE; R, result, flags and the holding registers clear to 0; done=0.
  - Any in-flight command is discarded and produces no done pulse.
  - cmd_ready=1 in the cycle after the reset edge if reset is deasserted.
- cmd_ready = (state==IDLE); busy = !cmd_ready. Combinational from state only.
- Accept happens at an edge with cmd_valid && cmd_ready. At that edge:
  - All control fields are captured.
  - Raw operand A is latched. Raw operand B is latched from the MUX1_SELECT source, with R sampled at the accept edge.
  - Shift count CNT is captured:
    - LSL/LSR/ASR: min(shamt, W).
    - ROR: shamt mod W.
  - Next state: SHIFT if CNT>0, else EXEC.
- cmd_valid is ignored while busy; fields need only be stable in the accept cycle.
- SHIFT state:
  - Each cycle shifts B by one bit in the selected direction and decrements CNT.
  - Fill: LSL/LSR fill 0; ASR fills the sign bit; ROR rotates.
  - The bit shifted out is stored as shifter carry SC.
  - Go to EXEC when CNT reaches 0.
- EXEC state (one cycle). Operand B = op2_mux2_select ? shifted B : comp2_mux2_inp_1. ALU per opcode, width W, wrap-around:
  - 0 AND: A&B
  - 1 EOR: A^B
  - 2 SUB: A-B
  - 3 RSB: B-A
  - 4 ADD: A+B
  - 5 ADC: A+B+C
  - 6 SBC: A-B-!C
  - 7 RSC: B-A-!C
  - 8 TST: AND
  - 9 TEQ: EOR
  - 10 CMP: SUB
  - 11 CMN: ADD
  - 12 ORR: A|B
  - 13 MOV: B
  - 14 BIC: A&~B
  - 15 MVN: ~B
- Commit at the EXEC edge:
  - result <= ALU value.
  - R <= ALU value only if write_enable=1 and opcode not in 8..11.
  - done <= 1 for exactly one cycle. State -> IDLE.
- Flags update on every commit:
  - N = result[W-1]; Z = (result==0).
  - Arithmetic ops (2-7, 10, 11):
    - C is the unsigned carry out, and for subtract forms C = NOT borrow.
    - V is signed overflow.
  - Logical ops: C = SC if CNT was nonzero, else unchanged; V unchanged.
- Latency: accept at edge k → done high in the cycle after edge k+CNT+1.
- A new command may be accepted in the same cycle that done is high (state is IDLE).

Test Plan:
- Reset, then MUX1_SELECT=1, MUX1_INP1=0xA3, op 13, shamt 0, op2_mux2_select=1, write_enable=1 → done after 2 edges; reg_out=0xA3, flags N=1 Z=0.
- R=0xA3, MUX0_SELECT=0, op2_mux2_select=0, comp2_mux2_inp_1=1, op 4 → reg_out=0xA4, C=0 V=0; repeat from R=0xFF → reg_out=0x00, Z=1 C=1.
- MOV 0xA3, LSL shamt=3 → busy for 4 cycles, done at edge k+4, result=0x18, C=1; LSR 4 → 0x0A; ROR shamt=12 → 0x3A (CNT=4); ASR shamt=9 → 0xFF (CNT=8).
- R=0x05, MUX1_INP1=0x05, MUX1_SELECT=1, MUX0_SELECT=0, op 10, write_enable=1 → R stays 0x05, Z=1 C=1; op 4 with write_enable=0 → result=0x0A, R still 0x05.
- cmd_valid held high across two back-to-back words → second is accepted only in the IDLE cycle where done=1, and both results commit in order.
- reset_synchronous asserted during SHIFT → no done pulse, reg_out=0, flags=0, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/datapath_executor_if.sv
// Command and status bundle between the task controller (master) and the
// datapath executor (slave).
interface datapath_executor_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic         MUX0_SELECT;
    logic [W-1:0] MUX0_INP1;
    logic         MUX1_SELECT;
    logic [W-1:0] MUX1_INP1;
    logic [4:0]   shamt;
    logic [1:0]   combinational_shifter_control;
    logic         op2_mux2_select;
    logic [W-1:0] comp2_mux2_inp_1;
    logic [3:0]   ALU_OPERATION_SELECT;
    logic         write_enable;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] reg_out;
    logic [3:0]   flags;

    modport master (
        output cmd_valid, MUX0_SELECT, MUX0_INP1, MUX1_SELECT, MUX1_INP1, shamt,
               combinational_shifter_control, op2_mux2_select, comp2_mux2_inp_1,
               ALU_OPERATION_SELECT, write_enable,
        input  cmd_ready, busy, done, result, reg_out, flags
    );

    modport slave (
        input  cmd_valid, MUX0_SELECT, MUX0_INP1, MUX1_SELECT, MUX1_INP1, shamt,
               combinational_shifter_control, op2_mux2_select, comp2_mux2_inp_1,
               ALU_OPERATION_SELECT, write_enable,
        output cmd_ready, busy, done, result, reg_out, flags
    );
endinterface

// File: rtl/datapath_executor.sv
// Sequential datapath: captures a control word, shifts operand B one bit per
// cycle, then runs the ALU and commits result, register R and NZCV flags.
module datapath_executor #(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               reset_synchronous,
    datapath_executor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, comp_q, comp_d;
    logic [W-1:0] r_q, r_d, result_q, result_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [3:0]   op_q, op_d, flags_q, flags_d;
    logic [1:0]   ctl_q, ctl_d;
    logic         sc_q, sc_d, shifted_q, shifted_d;
    logic         o2s_q, o2s_d, we_q, we_d, done_q, done_d;

    logic [4:0]   cnt_cap_s;
    logic [W:0]   step_s;
    logic [W-1:0] b_op_s, add_x_s, add_y_s, alu_s;
    logic         add_cin_s, add_v_s, arith_s;
    logic [W:0]   sum_s;

    // One shifter step; returns {bit shifted out, new value}.
    function automatic logic [W:0] shift_step(input logic [W-1:0] v, input logic [1:0] ctl);
        logic [W:0] r;
        case (ctl)
            2'b00:   r = {v, 1'b0};
            2'b01:   r = {v[0], 1'b0, v[W-1:1]};
            2'b10:   r = {v[0], v[W-1], v[W-1:1]};
            2'b11:   r = {v[0], v[0], v[W-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    // Shift count: linear shifts saturate at W, rotates wrap modulo W.
    always_comb begin
        if (bus.combinational_shifter_control == 2'b11) begin
            cnt_cap_s = 5'({27'd0, bus.shamt} % 32'(W));
        end else if ({27'd0, bus.shamt} > 32'(W)) begin
            cnt_cap_s = 5'(W);
        end else begin
            cnt_cap_s = bus.shamt;
        end
    end

    // Shared adder; subtract forms use x + ~y + cin so carry out is NOT borrow.
    always_comb begin
        b_op_s    = o2s_q ? b_q : comp_q;
        add_x_s   = a_q;
        add_y_s   = b_op_s;
        add_cin_s = 1'b0;
        case (op_q)
            4'd2, 4'd10: begin add_y_s = ~b_op_s; add_cin_s = 1'b1; end
            4'd3:        begin add_x_s = b_op_s; add_y_s = ~a_q; add_cin_s = 1'b1; end
            4'd5:        add_cin_s = flags_q[1];
            4'd6:        begin add_y_s = ~b_op_s; add_cin_s = flags_q[1]; end
            4'd7:        begin add_x_s = b_op_s; add_y_s = ~a_q; add_cin_s = flags_q[1]; end
            default:     add_cin_s = 1'b0;
        endcase
        sum_s   = {1'b0, add_x_s} + {1'b0, add_y_s} + {{W{1'b0}}, add_cin_s};
        add_v_s = (add_x_s[W-1] == add_y_s[W-1]) && (sum_s[W-1] != add_x_s[W-1]);
    end

    // ALU result select.
    always_comb begin
        arith_s = 1'b0;
        case (op_q)
            4'd0, 4'd8: alu_s = a_q & b_op_s;
            4'd1, 4'd9: alu_s = a_q ^ b_op_s;
            4'd12:      alu_s = a_q | b_op_s;
            4'd13:      alu_s = b_op_s;
            4'd14:      alu_s = a_q & ~b_op_s;
            4'd15:      alu_s = ~b_op_s;
            default: begin
                alu_s   = sum_s[W-1:0];
                arith_s = 1'b1;
            end
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        comp_d    = comp_q;
        r_d       = r_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        flags_d   = flags_q;
        ctl_d     = ctl_q;
        sc_d      = sc_q;
        shifted_d = shifted_q;
        o2s_d     = o2s_q;
        we_d      = we_q;
        done_d    = 1'b0;
        step_s    = shift_step(b_q, ctl_q);
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    a_d       = bus.MUX0_SELECT ? bus.MUX0_INP1 : r_q;
                    b_d       = bus.MUX1_SELECT ? bus.MUX1_INP1 : r_q;
                    comp_d    = bus.comp2_mux2_inp_1;
                    op_d      = bus.ALU_OPERATION_SELECT;
                    ctl_d     = bus.combinational_shifter_control;
                    o2s_d     = bus.op2_mux2_select;
                    we_d      = bus.write_enable;
                    cnt_d     = cnt_cap_s;
                    shifted_d = (cnt_cap_s != 5'd0);
                    sc_d      = 1'b0;
                    state_d   = (cnt_cap_s != 5'd0) ? SHIFT : EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                b_d     = step_s[W-1:0];
                sc_d    = step_s[W];
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd1) ? EXEC : SHIFT;
            end
            EXEC: begin
                result_d = alu_s;
                if (we_q && !(op_q inside {[4'd8:4'd11]})) begin
                    r_d = alu_s;
                end else begin
                    r_d = r_q;
                end
                flags_d[3] = alu_s[W-1];
                flags_d[2] = (alu_s == {W{1'b0}});
                if (arith_s) begin
                    flags_d[1] = sum_s[W];
                    flags_d[0] = add_v_s;
                end else if (shifted_q) begin
                    flags_d[1] = sc_q;
                end else begin
                    flags_d[1] = flags_q[1];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_synchronous) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            comp_q    <= '0;
            r_q       <= '0;
            result_q  <= '0;
            cnt_q     <= 5'd0;
            op_q      <= 4'd0;
            flags_q   <= 4'd0;
            ctl_q     <= 2'd0;
            sc_q      <= 1'b0;
            shifted_q <= 1'b0;
            o2s_q     <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            comp_q    <= comp_d;
            r_q       <= r_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            flags_q   <= flags_d;
            ctl_q     <= ctl_d;
            sc_q      <= sc_d;
            shifted_q <= shifted_d;
            o2s_q     <= o2s_d;
            we_q      <= we_d;
            done_q    <= done_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.reg_out   = r_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_datapath_executor.sv
// Directed and randomized bench for datapath_executor against an arithmetic
// reference model of the command semantics.
module tb_datapath_executor;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_executor_if #(.W(W)) bus();
    datapath_executor #(.W(W)) dut (
        .clk               (clk),
        .reset_synchronous (rst),
        .bus               (bus)
    );

    typedef struct {
        bit       m0s;
        bit [7:0] m0i;
        bit       m1s;
        bit [7:0] m1i;
        bit [4:0] sh;
        bit [1:0] ctl;
        bit       o2s;
        bit [7:0] comp;
        bit [3:0] op;
        bit       we;
    } cmd_t;

    int       vectors     = 0;
    int       miscompares = 0;
    int       m_r   = 0;
    int       m_res = 0;
    bit [3:0] m_flags = 4'd0;
    int       m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v > MASK / 2) ? v - (MASK + 1) : v;
    endfunction

    function automatic cmd_t mk(input bit m0s, input bit [7:0] m0i, input bit m1s,
                                input bit [7:0] m1i, input bit [4:0] sh, input bit [1:0] ctl,
                                input bit o2s, input bit [7:0] comp, input bit [3:0] op,
                                input bit we);
        cmd_t c;
        c.m0s = m0s; c.m0i = m0i; c.m1s = m1s; c.m1i = m1i; c.sh = sh;
        c.ctl = ctl; c.o2s = o2s; c.comp = comp; c.op = op; c.we = we;
        return c;
    endfunction

    // Reference: whole-command semantics with integer arithmetic.
    function automatic void model(input cmd_t c);
        int a, b, n, x, bs, bb, sc, full, sfull, res;
        bit arith, sub, cin;
        a  = c.m0s ? int'(c.m0i) : m_r;
        b  = c.m1s ? int'(c.m1i) : m_r;
        n  = (c.ctl == 2'd3) ? int'(c.sh) % W : ((int'(c.sh) > W) ? W : int'(c.sh));
        bs = b;
        sc = 0;
        if (n > 0) begin
            case (c.ctl)
                2'd0: begin x = b << n; bs = x & MASK; sc = (x >> W) & 1; end
                2'd1: begin bs = b >> n; sc = (b >> (n - 1)) & 1; end
                2'd2: begin bs = (sx(b) >>> n) & MASK; sc = (sx(b) >>> (n - 1)) & 1; end
                default: begin bs = ((b >> n) | (b << (W - n))) & MASK; sc = (bs >> (W - 1)) & 1; end
            endcase
        end
        bb    = c.o2s ? bs : int'(c.comp);
        cin   = m_flags[1];
        arith = 1'b1;
        sub   = 1'b0;
        full  = 0;
        sfull = 0;
        res   = 0;
        case (c.op)
            4'd0, 4'd8:  begin res = a & bb; arith = 1'b0; end
            4'd1, 4'd9:  begin res = a ^ bb; arith = 1'b0; end
            4'd12:       begin res = a | bb; arith = 1'b0; end
            4'd13:       begin res = bb; arith = 1'b0; end
            4'd14:       begin res = a & ~bb & MASK; arith = 1'b0; end
            4'd15:       begin res = ~bb & MASK; arith = 1'b0; end
            4'd2, 4'd10: begin full = a - bb; sfull = sx(a) - sx(bb); sub = 1'b1; end
            4'd3:        begin full = bb - a; sfull = sx(bb) - sx(a); sub = 1'b1; end
            4'd5:        begin full = a + bb + int'(cin); sfull = sx(a) + sx(bb) + int'(cin); end
            4'd6:        begin full = a - bb - int'(!cin); sfull = sx(a) - sx(bb) - int'(!cin); sub = 1'b1; end
            4'd7:        begin full = bb - a - int'(!cin); sfull = sx(bb) - sx(a) - int'(!cin); sub = 1'b1; end
            default:     begin full = a + bb; sfull = sx(a) + sx(bb); end
        endcase
        if (arith) begin
            res        = full & MASK;
            m_flags[1] = sub ? (full >= 0) : (full > MASK);
            m_flags[0] = (sfull > MASK / 2) || (sfull < -(MASK / 2) - 1);
        end else if (n > 0) begin
            m_flags[1] = sc[0];
        end
        m_flags[3] = res[W-1];
        m_flags[2] = (res == 0);
        m_res = res;
        if (c.we && !(c.op inside {[4'd8:4'd11]})) m_r = res;
        m_cnt = n;
    endfunction

    task automatic drive(input cmd_t c, input logic v);
        bus.cmd_valid                     = v;
        bus.MUX0_SELECT                   = c.m0s;
        bus.MUX0_INP1                     = c.m0i;
        bus.MUX1_SELECT                   = c.m1s;
        bus.MUX1_INP1                     = c.m1i;
        bus.shamt                         = c.sh;
        bus.combinational_shifter_control = c.ctl;
        bus.op2_mux2_select               = c.o2s;
        bus.comp2_mux2_inp_1              = c.comp;
        bus.ALU_OPERATION_SELECT          = c.op;
        bus.write_enable                  = c.we;
    endtask

    // Waits (bounded) for done; cyc counts falling edges since the accept edge.
    task automatic wait_done_and_check(input string tag, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (bus.done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, cyc, m_cnt + 2);
        check({tag, "/result"}, bus.result, m_res);
        check({tag, "/reg_out"}, bus.reg_out, m_r);
        check({tag, "/flags"}, bus.flags, m_flags);
    endtask

    task automatic run(input cmd_t c, input string tag);
        @(negedge clk);
        check({tag, "/ready"}, bus.cmd_ready, 1);
        drive(c, 1'b1);
        model(c);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, "/busy"}, bus.busy, 1);
        wait_done_and_check(tag, 1);
    endtask

    initial begin
        cmd_t c1, c2;
        bit   done_seen;
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst/ready", bus.cmd_ready, 1);
        check("rst/busy", bus.busy, 0);
        check("rst/done", bus.done, 0);
        check("rst/state", {bus.result, bus.reg_out, bus.flags}, 0);

        run(mk(1, 0, 1, 8'hA3, 0, 0, 1, 0, 13, 1), "mov_a3");
        check("mov_a3/const", {bus.reg_out, bus.flags[3:2]}, {8'hA3, 2'b10});
        run(mk(0, 0, 1, 0, 0, 0, 0, 8'h01, 4, 1), "add_a4");
        check("add_a4/const", {bus.reg_out, bus.flags[1:0]}, {8'hA4, 2'b00});
        run(mk(1, 0, 1, 8'hFF, 0, 0, 1, 0, 13, 1), "mov_ff");
        run(mk(0, 0, 1, 0, 0, 0, 0, 8'h01, 4, 1), "add_wrap");
        check("add_wrap/const", {bus.reg_out, bus.flags}, {8'h00, 4'b0110});

        run(mk(1, 0, 1, 8'hA3, 3, 0, 1, 0, 13, 1), "lsl3");
        check("lsl3/const", {bus.result, bus.flags[1]}, {8'h18, 1'b1});
        run(mk(1, 0, 1, 8'hA3, 4, 1, 1, 0, 13, 1), "lsr4");
        check("lsr4/const", bus.result, 8'h0A);
        run(mk(1, 0, 1, 8'hA3, 12, 3, 1, 0, 13, 1), "ror12");
        check("ror12/const", bus.result, 8'h3A);
        run(mk(1, 0, 1, 8'hA3, 9, 2, 1, 0, 13, 1), "asr9");
        check("asr9/const", bus.result, 8'hFF);

        run(mk(1, 0, 1, 8'h05, 0, 0, 1, 0, 13, 1), "mov_05");
        run(mk(0, 0, 1, 8'h05, 0, 0, 1, 0, 10, 1), "cmp");
        check("cmp/const", {bus.reg_out, bus.flags[2:1]}, {8'h05, 2'b11});
        run(mk(0, 0, 1, 8'h05, 0, 0, 1, 0, 4, 0), "add_nowe");
        check("add_nowe/const", {bus.result, bus.reg_out}, {8'h0A, 8'h05});

        // Back-to-back: valid held high; second word waits for the done cycle.
        c1 = mk(1, 8'h10, 1, 8'h33, 2, 0, 1, 0, 4, 1);
        c2 = mk(0, 0, 1, 8'h07, 1, 1, 1, 0, 2, 1);
        @(negedge clk);
        drive(c1, 1'b1);
        model(c1);
        @(negedge clk);
        drive(c2, 1'b1);
        wait_done_and_check("b2b_first", 1);
        check("b2b/ready_in_done", bus.cmd_ready, 1);
        model(c2);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("b2b/second_busy", bus.busy, 1);
        wait_done_and_check("b2b_second", 1);

        // Reset while shifting discards the command.
        @(negedge clk);
        drive(mk(1, 0, 1, 8'hA3, 20, 0, 1, 0, 13, 1), 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_r = 0; m_res = 0; m_flags = 4'd0;
        check("rst_shift/ready", bus.cmd_ready, 1);
        check("rst_shift/state", {bus.done, bus.result, bus.reg_out, bus.flags}, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            done_seen |= bus.done;
        end
        check("rst_shift/no_done", done_seen, 0);

        for (int i = 0; i < 150; i++) begin
            c1 = mk(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 5'($urandom),
                    2'($urandom), 1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
            run(c1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
